// File: rtl/ptp_round_scheduler.sv
// ptp_round_scheduler: rotates the PTP master role across masked piezo
// endpoints, gathers slave travel times and streams them out.
module ptp_round_scheduler #(
  parameter int N_NODES       = 4,
  parameter int RST_CYCLES    = 16,
  parameter int ROUND_TIMEOUT = 50000000,
  parameter int REQ_SAMPLES   = 2,
  localparam int IDXW         = $clog2(N_NODES)
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [N_NODES-1:0]     node_mask,
  input  logic [N_NODES-1:0]     tt_valid,
  input  logic [32*N_NODES-1:0]  tt_data,
  output logic [N_NODES-1:0]     sync_en,
  output logic [N_NODES-1:0]     master_sel,
  output logic                   node_reset,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [IDXW-1:0]        res_master,
  output logic [IDXW-1:0]        res_slave,
  output logic [31:0]            res_time,
  output logic                   res_timeout,
  output logic                   busy,
  output logic                   done,
  output logic                   start_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RESET,
    S_COLLECT,
    S_EMIT
  } state_t;

  localparam logic [3:0]  REQ      = 4'(REQ_SAMPLES);
  localparam logic [31:0] RST_LAST = 32'(RST_CYCLES - 1);
  localparam logic [31:0] TO_LAST  = 32'(ROUND_TIMEOUT - 1);

  state_t             state_q;
  state_t             state_n;
  logic [N_NODES-1:0] mask_q;
  logic [N_NODES-1:0] mask_n;
  logic [IDXW-1:0]    master_q;
  logic [IDXW-1:0]    master_n;
  logic [IDXW-1:0]    slave_q;
  logic [IDXW-1:0]    slave_n;
  logic               done_n;
  logic               err_n;
  logic [31:0]        rst_cnt_q;
  logic [31:0]        to_cnt_q;
  logic [3:0]         cnt_q [N_NODES];
  logic [3:0]         cnt_n [N_NODES];
  logic [31:0]        time_q [N_NODES];
  logic [N_NODES-1:0] hit;
  logic [N_NODES-1:0] master_oh;
  logic [N_NODES-1:0] slaves;
  logic               complete;
  logic [IDXW:0]      pop;
  logic [IDXW:0]      first_mst;
  logic [IDXW:0]      first_slv;
  logic [IDXW:0]      next_slv;
  logic [IDXW:0]      next_mst;

  // Lowest set index at or above 'from'; MSB of the result flags a hit.
  function automatic logic [IDXW:0] find_from(
    input logic [N_NODES-1:0] v,
    input logic [IDXW:0]      from
  );
    logic [IDXW:0] r;
    r = '0;
    for (int i = N_NODES - 1; i >= 0; i--) begin
      if (v[i] && i >= int'(from)) begin
        r = {1'b1, IDXW'(i)};
      end
    end
    return r;
  endfunction

  assign master_oh = N_NODES'(1) << master_q;
  assign slaves    = mask_q & ~master_oh;

  assign first_mst = find_from(node_mask, '0);
  assign first_slv = find_from(slaves, '0);
  assign next_slv  = find_from(slaves,
                       (IDXW+1)'(slave_q) + (IDXW+1)'(1));
  assign next_mst  = find_from(mask_q,
                       (IDXW+1)'(master_q) + (IDXW+1)'(1));

  // Population count of the requested mask for start qualification
  always_comb begin
    pop = '0;
    for (int i = 0; i < N_NODES; i++) begin
      pop = pop + (IDXW+1)'(node_mask[i]);
    end
  end

  // Slave report filtering, saturating counts and round completion
  always_comb begin
    hit      = '0;
    complete = 1'b1;
    for (int i = 0; i < N_NODES; i++) begin
      hit[i]   = (state_q == S_COLLECT) && tt_valid[i] && slaves[i];
      cnt_n[i] = cnt_q[i];
      if (hit[i] && cnt_q[i] != REQ) begin
        cnt_n[i] = cnt_q[i] + 4'd1;
      end
      if (slaves[i] && cnt_n[i] != REQ) begin
        complete = 1'b0;
      end
    end
  end

  // Next-state logic and Moore outputs
  always_comb begin
    state_n     = state_q;
    mask_n      = mask_q;
    master_n    = master_q;
    slave_n     = slave_q;
    done_n      = 1'b0;
    err_n       = 1'b0;
    sync_en     = '0;
    master_sel  = '0;
    node_reset  = 1'b0;
    res_valid   = 1'b0;
    res_master  = '0;
    res_slave   = '0;
    res_time    = '0;
    res_timeout = 1'b0;
    busy        = (state_q != S_IDLE);

    if (abort) begin
      state_n = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            if (pop < (IDXW+1)'(2)) begin
              err_n = 1'b1;
            end else begin
              mask_n   = node_mask;
              master_n = first_mst[IDXW-1:0];
              state_n  = S_RESET;
            end
          end
        end
        S_RESET: begin
          if (rst_cnt_q == RST_LAST) begin
            state_n = S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (complete || to_cnt_q == TO_LAST) begin
            state_n = S_EMIT;
            slave_n = first_slv[IDXW-1:0];
          end
        end
        S_EMIT: begin
          if (res_ready) begin
            if (next_slv[IDXW]) begin
              slave_n = next_slv[IDXW-1:0];
            end else if (next_mst[IDXW]) begin
              master_n = next_mst[IDXW-1:0];
              state_n  = S_RESET;
            end else begin
              done_n  = 1'b1;
              state_n = S_IDLE;
            end
          end
        end
        default: state_n = S_IDLE;
      endcase
    end

    unique case (state_q)
      S_RESET: begin
        node_reset = 1'b1;
        master_sel = master_oh;
      end
      S_COLLECT: begin
        sync_en    = mask_q;
        master_sel = master_oh;
      end
      S_EMIT: begin
        master_sel  = master_oh;
        res_valid   = 1'b1;
        res_master  = master_q;
        res_slave   = slave_q;
        res_timeout = (cnt_q[slave_q] != REQ);
        res_time    = res_timeout ? 32'hFFFF_FFFF
                                  : time_q[slave_q];
      end
      default: ;
    endcase
  end

  // Control state and single-cycle status pulses
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      mask_q    <= '0;
      master_q  <= '0;
      slave_q   <= '0;
      done      <= 1'b0;
      start_err <= 1'b0;
    end else begin
      state_q   <= state_n;
      mask_q    <= mask_n;
      master_q  <= master_n;
      slave_q   <= slave_n;
      done      <= done_n;
      start_err <= err_n;
    end
  end

  // Round timers and per-node travel-time capture
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rst_cnt_q <= '0;
      to_cnt_q  <= '0;
      for (int i = 0; i < N_NODES; i++) begin
        cnt_q[i]  <= '0;
        time_q[i] <= '0;
      end
    end else begin
      rst_cnt_q <= (state_q == S_RESET) ? rst_cnt_q + 32'd1 : '0;
      to_cnt_q  <= (state_q == S_COLLECT) ? to_cnt_q + 32'd1 : '0;
      for (int i = 0; i < N_NODES; i++) begin
        if (state_q == S_RESET) begin
          cnt_q[i]  <= '0;
          time_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_n[i];
          if (hit[i]) begin
            time_q[i] <= tt_data[32*i +: 32];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ptp_round_scheduler.sv
// tb_ptp_round_scheduler: directed campaigns against a result-stream
// model built from the mask and the reports the bench sends.
module tb_ptp_round_scheduler;

  localparam int N    = 4;
  localparam int IW   = 2;
  localparam int RSTC = 16;
  localparam int TO   = 1000;
  localparam int REQ  = 2;

  logic            clock = 1'b0;
  logic            reset_n = 1'b1;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic            res_ready = 1'b1;
  logic [N-1:0]    node_mask = '0;
  logic [N-1:0]    tt_valid = '0;
  logic [32*N-1:0] tt_data = '0;
  logic [N-1:0]    sync_en;
  logic [N-1:0]    master_sel;
  logic            node_reset;
  logic            res_valid;
  logic [IW-1:0]   res_master;
  logic [IW-1:0]   res_slave;
  logic [31:0]     res_time;
  logic            res_timeout;
  logic            busy;
  logic            done;
  logic            start_err;

  typedef struct {
    int          m;
    int          s;
    logic [31:0] t;
    logic        to;
  } res_t;

  res_t         exp_q[$];
  res_t         log_q[$];
  logic [N-1:0] ms_log[$];
  int           n_checks = 0;
  int           n_fail = 0;
  int           done_cnt = 0;
  int           base;

  always #5 clock = ~clock;

  ptp_round_scheduler #(
    .N_NODES(N),
    .RST_CYCLES(RSTC),
    .ROUND_TIMEOUT(TO),
    .REQ_SAMPLES(REQ)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .start(start),
    .abort(abort),
    .node_mask(node_mask),
    .tt_valid(tt_valid),
    .tt_data(tt_data),
    .sync_en(sync_en),
    .master_sel(master_sel),
    .node_reset(node_reset),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_master(res_master),
    .res_slave(res_slave),
    .res_time(res_time),
    .res_timeout(res_timeout),
    .busy(busy),
    .done(done),
    .start_err(start_err)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Final report of slave s while m is master is the one that counts.
  function automatic logic [31:0] rep_val(int m, int s, int p);
    if (p == REQ - 1) return 32'(100 * s + 1000 * m);
    return 32'h5000 + 32'(s);
  endfunction

  // Model: every masked master, every other masked node, ascending.
  task automatic build_exp(input logic [N-1:0] mask, input bit tmo);
    res_t r;
    for (int m = 0; m < N; m++) begin
      if (!mask[m]) continue;
      for (int s = 0; s < N; s++) begin
        if (!mask[s] || s == m) continue;
        r.m  = m;
        r.s  = s;
        r.t  = tmo ? 32'hFFFF_FFFF : rep_val(m, s, REQ - 1);
        r.to = tmo;
        exp_q.push_back(r);
      end
    end
  endtask

  function automatic logic cond_of(int which);
    case (which)
      0: return node_reset;
      1: return done;
      default: return res_valid;
    endcase
  endfunction

  task automatic wait_cond(input int which, input int budget,
                           input string name);
    int c;
    c = 0;
    do begin
      @(negedge clock);
      c++;
    end while (!cond_of(which) && c < budget);
    n_checks++;
    if (!cond_of(which)) begin
      n_fail++;
      $display("FAIL %s: not seen within %0d cycles", name, budget);
    end
  endtask

  task automatic start_campaign(input logic [N-1:0] mask);
    @(posedge clock);
    #1;
    node_mask = mask;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic pulse(input logic [N-1:0] v, input int p,
                       input int m, input bit bogus);
    @(posedge clock);
    #1;
    tt_valid = v;
    for (int s = 0; s < N; s++) begin
      tt_data[32*s +: 32] = bogus ? 32'hDEAD_0000 + 32'(s)
                                  : rep_val(m, s, p);
    end
    @(posedge clock);
    #1;
    tt_valid = '0;
  endtask

  // mode: 0 normal, 1 timeout, 2 filter+backpressure, 3 abort,
  // 4 reset during EMIT
  task automatic do_round(input int m, input logic [N-1:0] mask,
                          input int mode, input bit extra);
    logic [N-1:0] oh;
    logic [N-1:0] slv;
    logic [N-1:0] bog;
    int c;
    int nslv;
    oh = '0;
    oh[m] = 1'b1;
    slv = mask & ~oh;
    bog = oh | ~mask;
    nslv = $countones(slv);
    wait_cond(0, 64, "wait_node_reset");
    chk("master_sel_reset", master_sel, oh);
    chk("busy_reset", busy, 1);
    chk("sync_en_reset", sync_en, 0);
    ms_log.push_back(master_sel);
    c = 0;
    while (node_reset && c < RSTC + 8) begin
      c++;
      @(negedge clock);
    end
    chk("reset_len", c, RSTC);
    chk("sync_en_collect", sync_en, mask);
    chk("master_sel_collect", master_sel, oh);
    if (mode == 3) begin
      @(posedge clock);
      #1 abort = 1'b1;
      @(posedge clock);
      #1 abort = 1'b0;
      @(negedge clock);
      chk("abort_sync_en", sync_en, 0);
      chk("abort_master_sel", master_sel, 0);
      chk("abort_busy", busy, 0);
      chk("abort_node_reset", node_reset, 0);
      chk("abort_res_valid", res_valid, 0);
      return;
    end
    if (mode == 1) begin
      c = 0;
      while (sync_en != '0 && c < TO + 10) begin
        c++;
        @(negedge clock);
      end
      chk("collect_len", c, TO);
    end else begin
      if (extra) begin
        @(posedge clock);
        #1 node_mask = '1;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        node_mask = mask;
        @(negedge clock);
        chk("busy_start_master", master_sel, oh);
        chk("busy_start_sync", sync_en, mask);
      end
      if (mode == 2 || mode == 4) res_ready = 1'b0;
      for (int p = 0; p < REQ; p++) begin
        if (mode == 2) pulse(bog, 0, m, 1'b1);
        pulse(slv, p, m, 1'b0);
        if (p < REQ - 1) begin
          @(negedge clock);
          chk("collect_pending", res_valid, 0);
          chk("collect_sync_en", sync_en, mask);
        end
      end
      @(negedge clock);
    end
    chk("emit_entry_valid", res_valid, 1);
    chk("emit_entry_sync", sync_en, 0);
    if (mode == 4) begin
      #2 reset_n = 1'b0;
      #1;
      chk("rst_res_valid", res_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_master_sel", master_sel, 0);
      chk("rst_res_time", res_time, 0);
      exp_q.delete();
      @(posedge clock);
      #1 reset_n = 1'b1;
      res_ready = 1'b1;
      return;
    end
    if (mode == 2) begin
      repeat (20) begin
        @(negedge clock);
        chk("bp_valid", res_valid, 1);
      end
      @(posedge clock);
      #1 res_ready = 1'b1;
      @(negedge clock);
    end
    for (int k = 1; k < nslv; k++) begin
      @(negedge clock);
      chk("emit_back_to_back", res_valid, 1);
    end
  endtask

  task automatic finish_campaign();
    wait_cond(1, 64, "wait_done");
    chk("busy_at_done", busy, 0);
    chk("master_sel_at_done", master_sel, 0);
    @(negedge clock);
    chk("done_pulses", 64'(done_cnt - base), 1);
    chk("done_width", done, 0);
    chk("results_left", 64'(exp_q.size()), 0);
  endtask

  // Compare every presented result against the model stream
  always @(negedge clock) begin
    res_t r;
    if (reset_n) begin
      if (done) done_cnt++;
      if (res_valid) begin
        chk("emit_sync_en", sync_en, 0);
        chk("emit_node_reset", node_reset, 0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL extra_result: got m%0d s%0d, required none",
                   res_master, res_slave);
        end else begin
          chk("res_master", 64'(res_master), 64'(exp_q[0].m));
          chk("res_slave", 64'(res_slave), 64'(exp_q[0].s));
          chk("res_time", res_time, exp_q[0].t);
          chk("res_timeout", res_timeout, exp_q[0].to);
          if (res_ready && !abort) begin
            r.m  = int'(res_master);
            r.s  = int'(res_slave);
            r.t  = res_time;
            r.to = res_timeout;
            log_q.push_back(r);
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset_n = 1'b0;
    #20;
    chk("rst_busy0", busy, 0);
    chk("rst_outputs0",
        {sync_en, master_sel, node_reset, res_valid, done, start_err},
        0);
    chk("rst_res0", {res_master, res_slave, res_time, res_timeout}, 0);
    @(posedge clock);
    #1 reset_n = 1'b1;

    start_campaign(4'b0100);
    @(negedge clock);
    chk("start_err_pulse", start_err, 1);
    chk("start_err_busy", busy, 0);
    @(negedge clock);
    chk("start_err_width", start_err, 0);
    chk("start_err_idle", busy, 0);

    log_q.delete();
    ms_log.delete();
    base = done_cnt;
    build_exp(4'b0111, 1'b0);
    start_campaign(4'b0111);
    do_round(0, 4'b0111, 0, 1'b0);
    do_round(1, 4'b0111, 0, 1'b1);
    do_round(2, 4'b0111, 0, 1'b0);
    finish_campaign();
    chk("normal_count", 64'(log_q.size()), 6);
    chk("normal_r0", {32'(log_q[0].m), 32'(log_q[0].s)}, {32'd0, 32'd1});
    chk("normal_r0_time", log_q[0].t, 100);
    chk("normal_r1", {32'(log_q[1].m), 32'(log_q[1].s)}, {32'd0, 32'd2});
    chk("normal_r1_time", log_q[1].t, 200);
    chk("ms_seq0", ms_log[0], 4'b0001);
    chk("ms_seq1", ms_log[1], 4'b0010);
    chk("ms_seq2", ms_log[2], 4'b0100);

    log_q.delete();
    base = done_cnt;
    build_exp(4'b0011, 1'b1);
    start_campaign(4'b0011);
    do_round(0, 4'b0011, 1, 1'b0);
    do_round(1, 4'b0011, 1, 1'b0);
    finish_campaign();
    chk("tmo_r0", {32'(log_q[0].m), 32'(log_q[0].s)}, {32'd0, 32'd1});
    chk("tmo_r0_val", {log_q[0].t, 31'd0, log_q[0].to},
        {32'hFFFF_FFFF, 32'd1});
    chk("tmo_r1", {32'(log_q[1].m), 32'(log_q[1].s)}, {32'd1, 32'd0});
    chk("tmo_r1_val", {log_q[1].t, 31'd0, log_q[1].to},
        {32'hFFFF_FFFF, 32'd1});

    log_q.delete();
    base = done_cnt;
    build_exp(4'b1011, 1'b0);
    start_campaign(4'b1011);
    do_round(0, 4'b1011, 2, 1'b0);
    do_round(1, 4'b1011, 0, 1'b0);
    do_round(3, 4'b1011, 0, 1'b0);
    finish_campaign();
    chk("filter_count", 64'(log_q.size()), 6);

    base = done_cnt;
    build_exp(4'b0111, 1'b0);
    start_campaign(4'b0111);
    do_round(0, 4'b0111, 3, 1'b0);
    exp_q.delete();
    repeat (10) @(negedge clock);
    chk("abort_no_done", 64'(done_cnt - base), 0);
    chk("abort_idle", busy, 0);

    build_exp(4'b0011, 1'b0);
    start_campaign(4'b0011);
    do_round(0, 4'b0011, 4, 1'b0);
    @(negedge clock);
    chk("post_rst_idle", {busy, res_valid, sync_en}, 0);

    log_q.delete();
    base = done_cnt;
    build_exp(4'b0011, 1'b0);
    start_campaign(4'b0011);
    do_round(0, 4'b0011, 0, 1'b0);
    do_round(1, 4'b0011, 0, 1'b0);
    finish_campaign();
    chk("recover_count", 64'(log_q.size()), 2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
